// File: rtl/icache_assoc_pkg.sv
// Shared types, width helpers and pseudo-LRU helpers for the associative instruction cache.
package icache_assoc_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int words);
        return addr_w - $clog2(sets) - $clog2(words);
    endfunction

    // 4-way tree bits: b[0] picks the half, b[1] ways 0/1, b[2] ways 2/3; each points away from the last use.
    function automatic logic [1:0] plru_victim(input int ways, input logic [2:0] b);
        logic [1:0] v;
        v = 2'd0;
        if (ways == 4) v = b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
        else if (ways == 2) v = {1'b0, b[0]};
        return v;
    endfunction

    function automatic logic [2:0] plru_update(input int ways, input logic [2:0] b, input logic [1:0] w);
        logic [2:0] r;
        r = b;
        if (ways == 4) begin
            r[0] = ~w[1];
            if (w[1]) r[2] = ~w[0];
            else      r[1] = ~w[0];
        end else if (ways == 2) begin
            r[0] = ~w[0];
        end
        return r;
    endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_assoc_if
    import icache_assoc_pkg::*;
#(
    parameter int ADDR_W = 30,
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
);
    localparam int OFF_W = off_w(WORDS);

    // A fetch completes in the cycle proc_read=1 and proc_stall=0 (proc_addr held until then);
    // a refill completes in the cycle mem_read=1 and mem_ready=1 (mem_addr held until then).
    logic                      proc_read;
    logic [ADDR_W-1:0]         proc_addr;
    logic                      proc_stall;
    logic [WORD_W-1:0]         proc_rdata;
    logic                      flush;
    logic                      flush_busy;
    logic                      mem_read;
    logic [ADDR_W-OFF_W-1:0]   mem_addr;
    logic [WORDS*WORD_W-1:0]   mem_rdata;
    logic                      mem_ready;

    modport master (
        output proc_read, proc_addr, flush, mem_rdata, mem_ready,
        input  proc_stall, proc_rdata, flush_busy, mem_read, mem_addr
    );

    modport slave (
        input  proc_read, proc_addr, flush, mem_rdata, mem_ready,
        output proc_stall, proc_rdata, flush_busy, mem_read, mem_addr
    );

endinterface

// File: rtl/icache_way.sv
// One cache way: valid/tag/block storage for every set, tag compare on the lookup index.
module icache_way #(
    parameter int SETS    = 4,
    parameter int IDX_W   = 2,
    parameter int TAG_W   = 26,
    parameter int BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   rd_idx_i,
    input  logic [TAG_W-1:0]   rd_tag_i,
    output logic               hit_o,
    output logic               valid_o,
    output logic [BLOCK_W-1:0] rdata_o,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [BLOCK_W-1:0] wr_data_i,
    input  logic               clr_i,
    input  logic [IDX_W-1:0]   clr_idx_i
);
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [BLOCK_W-1:0] data_q [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (clr_i) valid_q[clr_idx_i] <= 1'b0;
            if (we_i)  valid_q[wr_idx_i]  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign valid_o = valid_q[rd_idx_i];
    assign hit_o   = valid_o && (tag_q[rd_idx_i] == rd_tag_i);
    assign rdata_o = data_q[rd_idx_i];

endmodule

// File: rtl/icache_assoc.sv
// Read-only set-associative instruction cache: lookup/refill/flush FSM, PLRU state and refill bypass.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int SETS   = 4,
    parameter int WORDS  = 4,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 30
) (
    input  logic           clk,
    input  logic           rst,
    icache_assoc_if.slave  bus,
    output state_e         state_o
);
    localparam int OFF_W   = off_w(WORDS);
    localparam int IDX_W   = idx_w(SETS);
    localparam int TAG_W   = tag_w(ADDR_W, SETS, WORDS);
    localparam int BLOCK_W = WORDS * WORD_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        victim_q, victim_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              flush_pend_q, flush_pend_d;
    logic [2:0]        plru_q [SETS];

    logic [ADDR_W-1:0] look_addr;
    logic [TAG_W-1:0]  look_tag;
    logic [IDX_W-1:0]  look_idx;
    logic [OFF_W-1:0]  look_off;
    logic [WAYS-1:0]   hit_w, vld_w;
    logic [BLOCK_W-1:0] blk_w [WAYS];
    logic              hit_any, flush_pend;
    logic [1:0]        hit_way, victim, plru_way;
    logic [WORD_W-1:0] hit_word, byp_word;
    logic              serve_hit, bypass, fill, clr, plru_upd, mem_read;

    // While refilling, the latched address drives the lookup so the victim line is addressed.
    assign look_addr  = (state_q == S_FETCH) ? addr_q : bus.proc_addr;
    assign look_tag   = look_addr[ADDR_W-1 -: TAG_W];
    assign look_idx   = look_addr[OFF_W +: IDX_W];
    assign look_off   = look_addr[OFF_W-1:0];
    assign flush_pend = flush_pend_q | bus.flush;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .BLOCK_W(BLOCK_W)) u_way (
            .clk       (clk),
            .rst       (rst),
            .rd_idx_i  (look_idx),
            .rd_tag_i  (look_tag),
            .hit_o     (hit_w[w]),
            .valid_o   (vld_w[w]),
            .rdata_o   (blk_w[w]),
            .we_i      (fill && !rst && (victim_q == 2'(w))),
            .wr_idx_i  (addr_q[OFF_W +: IDX_W]),
            .wr_tag_i  (addr_q[ADDR_W-1 -: TAG_W]),
            .wr_data_i (bus.mem_rdata),
            .clr_i     (clr),
            .clr_idx_i (cnt_q)
        );
    end

    always_comb begin
        hit_any  = |hit_w;
        hit_way  = 2'd0;
        hit_word = '0;
        victim   = plru_victim(WAYS, plru_q[look_idx]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_w[w]) hit_way = 2'(w);
            if (!vld_w[w]) victim = 2'(w);
        end
        for (int w = 0; w < WAYS; w++)
            for (int i = 0; i < WORDS; i++)
                if (hit_w[w] && look_off == OFF_W'(i)) hit_word = blk_w[w][i*WORD_W +: WORD_W];
        byp_word = '0;
        for (int i = 0; i < WORDS; i++)
            if (addr_q[OFF_W-1:0] == OFF_W'(i)) byp_word = bus.mem_rdata[i*WORD_W +: WORD_W];
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        victim_d     = victim_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend;
        serve_hit    = 1'b0;
        bypass       = 1'b0;
        fill         = 1'b0;
        clr          = 1'b0;
        plru_upd     = 1'b0;
        plru_way     = hit_way;
        mem_read     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush_pend) begin
                    state_d      = S_FLUSH;
                    cnt_d        = '0;
                    flush_pend_d = 1'b0;
                end else if (bus.proc_read) begin
                    if (hit_any) begin
                        serve_hit = 1'b1;
                        plru_upd  = 1'b1;
                    end else begin
                        addr_d   = bus.proc_addr;
                        victim_d = victim;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    fill     = 1'b1;
                    bypass   = 1'b1;
                    plru_upd = 1'b1;
                    plru_way = victim_q;
                    if (flush_pend) begin
                        state_d      = S_FLUSH;
                        cnt_d        = '0;
                        flush_pend_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                clr          = 1'b1;
                flush_pend_d = 1'b0;
                cnt_d        = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            victim_q     <= 2'd0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            victim_q     <= victim_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) plru_q[s] <= 3'd0;
        end else if (clr) begin
            plru_q[cnt_q] <= 3'd0;
        end else if (plru_upd) begin
            plru_q[look_idx] <= plru_update(WAYS, plru_q[look_idx], plru_way);
        end
    end

    assign bus.proc_stall = bus.proc_read && !serve_hit && !bypass;
    assign bus.proc_rdata = serve_hit ? hit_word : (bypass ? byp_word : '0);
    assign bus.mem_read   = mem_read;
    assign bus.mem_addr   = addr_q[ADDR_W-1:OFF_W];
    assign bus.flush_busy = flush_pend || (state_q == S_FLUSH);
    assign state_o        = state_q;

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: 2-way, 4-way and direct-mapped instances sharing one stimulus.
module tb_icache_assoc;
    import icache_assoc_pkg::*;

    localparam int AW   = 30;
    localparam int WW   = 32;
    localparam int WD   = 4;
    localparam int SETS = 4;
    localparam int MAW  = AW - 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              proc_read = 1'b0;
    logic [AW-1:0]     proc_addr = '0;
    logic              flush = 1'b0;
    logic              mem_ready = 1'b0;
    logic [WD*WW-1:0]  mem_rdata = '0;

    int                sel = 0;
    int                n_checks = 0;
    int                n_errors = 0;
    logic [WW-1:0]     exp_q [$];
    logic [MAW-1:0]    last_maddr;

    logic              stall_v [3];
    logic              mread_v [3];
    logic              fbusy_v [3];
    logic [WW-1:0]     rdata_v [3];
    logic [MAW-1:0]    maddr_v [3];
    state_e            st_v    [3];

    icache_assoc_if #(.ADDR_W(AW), .WORD_W(WW), .WORDS(WD)) bus [3] ();

    // instance 0: 2-way, 1: 4-way, 2: direct-mapped
    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].proc_read = proc_read;
        assign bus[g].proc_addr = proc_addr;
        assign bus[g].flush     = flush;
        assign bus[g].mem_ready = mem_ready;
        assign bus[g].mem_rdata = mem_rdata;
        icache_assoc #(
            .WAYS((g == 0) ? 2 : ((g == 1) ? 4 : 1)), .SETS(SETS), .WORDS(WD),
            .WORD_W(WW), .ADDR_W(AW)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .bus     (bus[g]),
            .state_o (st_v[g])
        );
        assign stall_v[g] = bus[g].proc_stall;
        assign mread_v[g] = bus[g].mem_read;
        assign fbusy_v[g] = bus[g].flush_busy;
        assign rdata_v[g] = bus[g].proc_rdata;
        assign maddr_v[g] = bus[g].mem_addr;
    end

    logic           o_stall, o_mread, o_fbusy;
    logic [WW-1:0]  o_rdata;
    logic [MAW-1:0] o_maddr;
    state_e         o_state;
    assign o_stall = stall_v[sel];
    assign o_mread = mread_v[sel];
    assign o_fbusy = fbusy_v[sel];
    assign o_rdata = rdata_v[sel];
    assign o_maddr = maddr_v[sel];
    assign o_state = st_v[sel];

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] ref_word(input logic [AW-1:0] a);
        return {2'b10, a} ^ 32'h0F0F_0000;
    endfunction

    function automatic logic [WD*WW-1:0] block_of(input logic [MAW-1:0] ma);
        logic [WD*WW-1:0] b;
        for (int i = 0; i < WD; i++) b[i*WW +: WW] = ref_word({ma, 2'(i)});
        return b;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; proc_read = 1'b0; flush = 1'b0; mem_ready = 1'b0; proc_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Holds a fetch until served, acting as memory (ready after 'delay' FETCH cycles); flush pulsed at cycle flush_at.
    task automatic do_read(input logic [AW-1:0] addr, input int delay, input int flush_at, input int exp_stall);
        int cyc, fcnt, nst;
        logic done;
        logic [WW-1:0] got;
        exp_q.push_back(ref_word(addr));
        cyc = 0; fcnt = 0; nst = 0; done = 1'b0; got = '0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            proc_read = 1'b1; proc_addr = addr; flush = (cyc == flush_at); mem_ready = 1'b0;
            #1;
            if (o_mread) begin
                mem_rdata = block_of(o_maddr);
                mem_ready = (fcnt == delay);
                if (mem_ready) last_maddr = o_maddr;
                fcnt++;
            end
            #1;
            if (o_stall) nst++;
            else begin
                done = 1'b1;
                got  = o_rdata;
            end
            cyc++;
        end
        check_eq($sformatf("done@%0h", addr), done, 1);
        check_eq($sformatf("stall@%0h", addr), nst, exp_stall);
        check_eq($sformatf("rdata@%0h", addr), got, exp_q.pop_front());
        @(negedge clk);
        proc_read = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        #1;
        check_eq("mread_after", o_mread, 0);
    endtask

    initial begin
        int nb;
        logic [AW-1:0] a;
        int d, ex;
        logic [AW-1:0] mtag [SETS];
        logic mval [SETS];

        // reset state on the 2-way instance
        sel = 0;
        do_reset();
        #1;
        check_eq("rst_stall", o_stall, 0);
        check_eq("rst_mread", o_mread, 0);
        check_eq("rst_maddr", o_maddr, 0);
        check_eq("rst_fbusy", o_fbusy, 0);
        check_eq("rst_rdata", o_rdata, 0);
        check_eq("rst_state", o_state, S_IDLE);
        proc_read = 1'b1; proc_addr = 30'h100;
        #1;
        check_eq("rst_stall_rd", o_stall, 1);
        proc_read = 1'b0;

        // miss with 3-cycle memory latency, then hit in the same block, then minimum stall
        do_read(30'h100, 3, -1, 4);
        check_eq("maddr_100", last_maddr, 28'h40);
        do_read(30'h101, 0, -1, 0);
        do_read(30'h200, 0, -1, 1);

        // 2-way LRU replacement in set 0
        do_reset();
        do_read(30'h000, 1, -1, 2);
        do_read(30'h010, 0, -1, 1);
        do_read(30'h000, 0, -1, 0);
        do_read(30'h020, 0, -1, 1);
        do_read(30'h003, 0, -1, 0);
        do_read(30'h012, 0, -1, 1);

        // flush pulse during a refill
        do_reset();
        do_read(30'h040, 0, -1, 1);
        do_read(30'h050, 0, -1, 1);
        do_read(30'h044, 0, -1, 1);
        do_read(30'h045, 0, -1, 0);
        do_read(30'h080, 2, 1, 3);
        nb = 0;
        while (o_fbusy && nb < 16) begin
            nb++;
            @(negedge clk);
            #1;
        end
        check_eq("flush_busy_cycles", nb, SETS);
        check_eq("flush_state", o_state, S_IDLE);
        do_read(30'h040, 0, -1, 1);
        do_read(30'h050, 0, -1, 1);
        do_read(30'h044, 0, -1, 1);
        do_read(30'h080, 0, -1, 1);

        // flush coinciding with a hit: hit held back, flush runs, then refetch
        do_read(30'h041, 0, 0, 6);

        // second flush pulse while flushing is absorbed
        nb = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            flush = (k == 0 || k == 2);
            #1;
            if (o_fbusy) nb++;
        end
        flush = 1'b0;
        check_eq("flush_absorb", nb, SETS + 1);

        // reset in the middle of a refill
        @(negedge clk);
        proc_read = 1'b1; proc_addr = 30'h300;
        #1;
        check_eq("rf_detect", o_stall, 1);
        @(negedge clk);
        #1;
        check_eq("rf_mread", o_mread, 1);
        check_eq("rf_maddr", o_maddr, 28'hC0);
        @(negedge clk);
        rst = 1'b1; mem_rdata = block_of(28'hC0); mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0; proc_read = 1'b0;
        #1;
        check_eq("rf_mread_drop", o_mread, 0);
        check_eq("rf_state", o_state, S_IDLE);
        do_read(30'h300, 1, -1, 2);

        // 4-way tree PLRU in set 1
        sel = 1;
        do_reset();
        do_read(30'h004, 0, -1, 1);
        do_read(30'h014, 0, -1, 1);
        do_read(30'h024, 0, -1, 1);
        do_read(30'h034, 0, -1, 1);
        do_read(30'h005, 0, -1, 0);
        do_read(30'h016, 0, -1, 0);
        do_read(30'h027, 0, -1, 0);
        do_read(30'h034, 0, -1, 0);
        do_read(30'h006, 0, -1, 0);
        do_read(30'h044, 0, -1, 1);
        do_read(30'h015, 0, -1, 0);
        do_read(30'h025, 0, -1, 1);
        do_read(30'h047, 0, -1, 0);
        do_read(30'h004, 0, -1, 0);
        do_read(30'h017, 0, -1, 0);
        do_read(30'h026, 0, -1, 0);
        do_read(30'h035, 0, -1, 1);
        do_read(30'h007, 0, -1, 1);

        // direct-mapped instance against a reference tag model
        sel = 2;
        do_reset();
        for (int s = 0; s < SETS; s++) begin
            mval[s] = 1'b0;
            mtag[s] = '0;
        end
        for (int n = 0; n < 40; n++) begin
            a  = AW'($urandom_range(0, 63));
            d  = $urandom_range(0, 3);
            ex = (mval[a[3:2]] && mtag[a[3:2]] == (a >> 4)) ? 0 : d + 1;
            do_read(a, d, -1, ex);
            mval[a[3:2]] = 1'b1;
            mtag[a[3:2]] = a >> 4;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
